core_hcu_pipe: RTL

Parametrised hazard control unit for the RV32I pipeline, replacing the fixed five-stage stall/flush logic.
- Tracks the destination register of every in-flight instruction from EX to the last stage in an internal scoreboard.
- Resolves RAW hazards by forwarding, or by stalling when forwarding is disabled or the writer is a load still in EX.
- Freezes the pipeline while instruction or data memory is outstanding, with latched DONE flags.
- Drives per-register write/flush enables and PC_WRITE, and keeps saturating hazard counters.

---
 rtl/core_hcu_pkg.sv | 27 ++
 rtl/core_hcu_if.sv | 48 ++++
 rtl/core_hcu_match.sv | 33 +++
 rtl/core_hcu_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/core_hcu_pkg.sv
// Shared definitions for the hazard control unit: stage indices, scoreboard
// entry layout and the memory-wait state encoding.
package core_hcu_pkg;

    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EX  = 2;
    localparam int MEM = 3;

    localparam int FWD_SEL_REGFILE = 0;

    // Scoreboard address field is sized for the widest register file we build; REG_AW must not exceed it
    localparam int SB_AW_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_AW_MAX-1:0] awaddr;
        logic                 awvalid;
        logic                 isload;
    } sb_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } frz_state_t;

endpackage

// File: rtl/core_hcu_if.sv
// Pipeline <-> hazard control unit signal bundle. The pipeline side is the
// master; the hazard unit is the slave.
interface core_hcu_if #(
    parameter int NSTAGES = 5,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
);
    localparam int SW = $clog2(NSTAGES);

    logic [REG_AW-1:0]  id_raddr1;
    logic [REG_AW-1:0]  id_raddr2;
    logic               id_rvalid1;
    logic               id_rvalid2;
    logic [REG_AW-1:0]  id_awaddr;
    logic               id_awvalid;
    logic               id_isload;
    logic               id_valid;
    logic               redirect;
    logic               imem_busy;
    logic               imem_done;
    logic               dmem_req;
    logic               dmem_done;

    logic [NSTAGES-2:0] stage_write;
    logic [NSTAGES-2:0] stage_flush;
    logic               pc_write;
    logic [SW-1:0]      fwd_sel1;
    logic [SW-1:0]      fwd_sel2;
    logic               retire;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   freeze_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output id_raddr1, id_raddr2, id_rvalid1, id_rvalid2, id_awaddr, id_awvalid,
               id_isload, id_valid, redirect, imem_busy, imem_done, dmem_req, dmem_done,
        input  stage_write, stage_flush, pc_write, fwd_sel1, fwd_sel2, retire,
               stall_cnt, freeze_cnt, flush_cnt
    );

    modport slave (
        input  id_raddr1, id_raddr2, id_rvalid1, id_rvalid2, id_awaddr, id_awvalid,
               id_isload, id_valid, redirect, imem_busy, imem_done, dmem_req, dmem_done,
        output stage_write, stage_flush, pc_write, fwd_sel1, fwd_sel2, retire,
               stall_cnt, freeze_cnt, flush_cnt
    );

endinterface

// File: rtl/core_hcu_match.sv
// Youngest-writer search for one source operand over the in-flight
// scoreboard entries (EX .. last stage).
module core_hcu_match
    import core_hcu_pkg::*;
#(
    parameter int NSTAGES = 5,
    parameter int REG_AW  = 5,
    parameter int SW      = $clog2(NSTAGES)
) (
    input  sb_entry_t [NSTAGES-1:EX] sb_i,
    input  logic [REG_AW-1:0]        raddr_i,
    input  logic                     rvalid_i,
    output logic                     hit_o,
    output logic [SW-1:0]            stage_o,
    output logic                     load_o
);

    always_comb begin
        hit_o   = 1'b0;
        stage_o = '0;
        load_o  = 1'b0;
        // Walk oldest to youngest so the youngest writer is the one left standing
        for (int k = NSTAGES - 1; k >= EX; k--) begin
            if (rvalid_i && (raddr_i != '0) && sb_i[k].valid && sb_i[k].awvalid &&
                (sb_i[k].awaddr == SB_AW_MAX'(raddr_i))) begin
                hit_o   = 1'b1;
                stage_o = SW'(k);
                load_o  = sb_i[k].isload;
            end
        end
    end

endmodule

// File: rtl/core_hcu_pipe.sv
// Hazard control unit: scoreboard of in-flight writers, forwarding/stall
// resolution, memory-wait freeze and saturating event counters.
//
// state | meaning
// RUN   | pipeline was not frozen last cycle; done flags are clear
// WAIT  | pipeline was frozen last cycle; done flags hold completions seen so far
module core_hcu_pipe
    import core_hcu_pkg::*;
#(
    parameter int NSTAGES = 5,
    parameter int REG_AW  = 5,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic      clk_i,
    input  logic      rst_i,
    core_hcu_if.slave hcu_io
);

    localparam int            SW       = $clog2(NSTAGES);
    localparam logic [SW-1:0] LAST_FWD = SW'(NSTAGES - 2);
    localparam logic [SW-1:0] EX_SEL   = SW'(EX);

    sb_entry_t [NSTAGES-1:EX] sb_q, sb_d;
    frz_state_t               state_q, state_d;
    logic                     idone_q, idone_d;
    logic                     ddone_q, ddone_d;
    logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]         freeze_cnt_q, freeze_cnt_d;
    logic [CNT_W-1:0]         flush_cnt_q, flush_cnt_d;

    logic                     hit1, hit2, load1, load2;
    logic [SW-1:0]            stage1, stage2;
    logic [SW-1:0]            fwd1, fwd2;
    logic                     stall;
    logic                     pend_imem, pend_dmem, freeze;
    logic                     redirect_act;
    logic [NSTAGES-2:0]       wr, fl;
    logic                     pc_wr;

    core_hcu_match #(.NSTAGES(NSTAGES), .REG_AW(REG_AW), .SW(SW)) u_match1 (
        .sb_i     (sb_q),
        .raddr_i  (hcu_io.id_raddr1),
        .rvalid_i (hcu_io.id_rvalid1),
        .hit_o    (hit1),
        .stage_o  (stage1),
        .load_o   (load1)
    );

    core_hcu_match #(.NSTAGES(NSTAGES), .REG_AW(REG_AW), .SW(SW)) u_match2 (
        .sb_i     (sb_q),
        .raddr_i  (hcu_io.id_raddr2),
        .rvalid_i (hcu_io.id_rvalid2),
        .hit_o    (hit2),
        .stage_o  (stage2),
        .load_o   (load2)
    );

    always_comb begin
        stall = 1'b0;
        fwd1  = SW'(FWD_SEL_REGFILE);
        fwd2  = SW'(FWD_SEL_REGFILE);
        if (FWD_EN != 0) begin
            stall = (hit1 && load1 && (stage1 == EX_SEL)) ||
                    (hit2 && load2 && (stage2 == EX_SEL));
            // The oldest stage is written through the regfile, so it keeps select 0
            if (hit1 && !(load1 && (stage1 == EX_SEL)) && (stage1 <= LAST_FWD)) begin
                fwd1 = stage1 + SW'(1);
            end
            if (hit2 && !(load2 && (stage2 == EX_SEL)) && (stage2 <= LAST_FWD)) begin
                fwd2 = stage2 + SW'(1);
            end
        end else begin
            stall = (hit1 && (stage1 <= LAST_FWD)) || (hit2 && (stage2 <= LAST_FWD));
        end
    end

    assign pend_imem    = hcu_io.imem_busy & ~hcu_io.imem_done & ~idone_q;
    assign pend_dmem    = hcu_io.dmem_req  & ~hcu_io.dmem_done & ~ddone_q;
    assign freeze       = pend_imem | pend_dmem;
    assign redirect_act = hcu_io.redirect & sb_q[EX].valid & ~freeze;

    always_comb begin
        state_d = state_q;
        idone_d = idone_q;
        ddone_d = ddone_q;
        case (state_q)
            ST_RUN: begin
                idone_d = freeze & hcu_io.imem_done;
                ddone_d = freeze & hcu_io.dmem_done;
                if (freeze) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                idone_d = freeze & (idone_q | hcu_io.imem_done);
                ddone_d = freeze & (ddone_q | hcu_io.dmem_done);
                if (!freeze) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        wr    = '1;
        fl    = '0;
        pc_wr = 1'b1;
        if (rst_i) begin
            wr    = '0;
            fl    = '1;
            pc_wr = 1'b0;
        end else if (freeze) begin
            wr    = '0;
            pc_wr = 1'b0;
        end else if (redirect_act) begin
            fl[IF] = 1'b1;
            fl[ID] = 1'b1;
        end else if (stall) begin
            wr[IF] = 1'b0;
            fl[ID] = 1'b1;
            pc_wr  = 1'b0;
        end
    end

    always_comb begin
        sb_d = sb_q;
        if (fl[ID]) begin
            sb_d[EX] = '0;
        end else if (wr[ID]) begin
            sb_d[EX].valid   = hcu_io.id_valid;
            sb_d[EX].awaddr  = SB_AW_MAX'(hcu_io.id_awaddr);
            sb_d[EX].awvalid = hcu_io.id_awvalid;
            sb_d[EX].isload  = hcu_io.id_isload;
        end
        for (int i = EX; i <= NSTAGES - 2; i++) begin
            if (fl[i]) begin
                sb_d[i+1] = '0;
            end else if (wr[i]) begin
                sb_d[i+1] = sb_q[i];
            end
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!freeze && !redirect_act && stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (freeze && (freeze_cnt_q != '1)) begin
            freeze_cnt_d = freeze_cnt_q + CNT_W'(1);
        end
        if (redirect_act && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idone_q <= idone_d;
            ddone_q <= ddone_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q         <= '0;
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            sb_q         <= sb_d;
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign hcu_io.stage_write = wr;
    assign hcu_io.stage_flush = fl;
    assign hcu_io.pc_write    = pc_wr;
    assign hcu_io.fwd_sel1    = rst_i ? SW'(FWD_SEL_REGFILE) : fwd1;
    assign hcu_io.fwd_sel2    = rst_i ? SW'(FWD_SEL_REGFILE) : fwd2;
    assign hcu_io.retire      = sb_q[NSTAGES-1].valid;
    assign hcu_io.stall_cnt   = stall_cnt_q;
    assign hcu_io.freeze_cnt  = freeze_cnt_q;
    assign hcu_io.flush_cnt   = flush_cnt_q;

endmodule
